// File: rtl/issue_queue_2w.sv
// Dual-dispatch, dual-issue collapsing issue queue. Entry 0 is always the oldest;
// up to two oldest ready entries issue per cycle and wake dependents via sel_inst*_dest.
module issue_queue_2w #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [1:0]                disp_valid,
    output logic                      disp_ready,
    input  logic [1:0][REG_W-1:0]     disp_src1,
    input  logic [1:0][REG_W-1:0]     disp_src2,
    input  logic [1:0]                disp_src1_rdy,
    input  logic [1:0]                disp_src2_rdy,
    input  logic [1:0][REG_W-1:0]     disp_dest,
    input  logic [1:0]                disp_rf_we,
    input  logic [1:0][PAYLOAD_W-1:0] disp_payload,
    output logic [1:0]                iss_valid,
    input  logic                      iss_ready,
    output logic [1:0][PAYLOAD_W-1:0] iss_payload,
    output logic [REG_W-1:0]          sel_inst1_dest,
    output logic [REG_W-1:0]          sel_inst2_dest,
    input  logic [REG_W-1:0]          wb_inst1_dest,
    input  logic [REG_W-1:0]          wb_inst2_dest,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic                 valid;
        logic [REG_W-1:0]     src1;
        logic [REG_W-1:0]     src2;
        logic                 rdy1;
        logic                 rdy2;
        logic [REG_W-1:0]     dest;
        logic                 rf_we;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] remove;
    logic             sel0_found;
    logic             sel1_found;
    logic [IDX_W-1:0] sel0_idx;
    logic [IDX_W-1:0] sel1_idx;
    logic             disp_fire;

    // Source wakes on any nonzero tag match; register 0 never needs a wakeup.
    function automatic logic tag_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] t0,
                                     input logic [REG_W-1:0] t1,
                                     input logic [REG_W-1:0] t2,
                                     input logic [REG_W-1:0] t3);
        return (src != '0) && ((src == t0) || (src == t1) || (src == t2) || (src == t3));
    endfunction

    // Oldest-first select of two ready entries from registered state.
    always_comb begin
        rdy_vec        = '0;
        remove         = '0;
        sel0_found     = 1'b0;
        sel1_found     = 1'b0;
        sel0_idx       = '0;
        sel1_idx       = '0;
        iss_valid      = '0;
        iss_payload    = '0;
        sel_inst1_dest = '0;
        sel_inst2_dest = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy_vec[IDX_W'(i)] = ent_q[IDX_W'(i)].valid && ent_q[IDX_W'(i)].rdy1 && ent_q[IDX_W'(i)].rdy2;
            if (rdy_vec[IDX_W'(i)]) begin
                if (!sel0_found) begin
                    sel0_found = 1'b1;
                    sel0_idx   = IDX_W'(i);
                end else if (!sel1_found) begin
                    sel1_found = 1'b1;
                    sel1_idx   = IDX_W'(i);
                end
            end
        end
        iss_valid = {sel1_found, sel0_found};
        if (sel0_found) begin
            iss_payload[0] = ent_q[sel0_idx].payload;
            if (iss_ready) begin
                remove[sel0_idx] = 1'b1;
                if (ent_q[sel0_idx].rf_we) sel_inst1_dest = ent_q[sel0_idx].dest;
            end
        end
        if (sel1_found) begin
            iss_payload[1] = ent_q[sel1_idx].payload;
            if (iss_ready) begin
                remove[sel1_idx] = 1'b1;
                if (ent_q[sel1_idx].rf_we) sel_inst2_dest = ent_q[sel1_idx].dest;
            end
        end
    end

    assign disp_ready = (CNT_W'(DEPTH) - occ_q) >= CNT_W'(2);
    assign disp_fire  = disp_valid[0] && disp_ready;
    assign occupancy  = occ_q;

    // Compact surviving entries toward index 0, apply wakeups, then append dispatches.
    always_comb begin
        entry_t           e;
        logic [CNT_W-1:0] wr;
        e  = '0;
        wr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[IDX_W'(i)] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            e = ent_q[IDX_W'(i)];
            if (e.valid && !remove[IDX_W'(i)]) begin
                e.rdy1 = e.rdy1 | tag_hit(e.src1, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                e.rdy2 = e.rdy2 | tag_hit(e.src2, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                ent_d[IDX_W'(wr)] = e;
                wr = wr + CNT_W'(1);
            end
        end
        if (disp_fire) begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (disp_valid[1'(s)]) begin
                    e.valid   = 1'b1;
                    e.src1    = disp_src1[1'(s)];
                    e.src2    = disp_src2[1'(s)];
                    e.rdy1    = disp_src1_rdy[1'(s)] || (disp_src1[1'(s)] == '0) ||
                                tag_hit(disp_src1[1'(s)], sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                    e.rdy2    = disp_src2_rdy[1'(s)] || (disp_src2[1'(s)] == '0) ||
                                tag_hit(disp_src2[1'(s)], sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                    e.dest    = disp_dest[1'(s)];
                    e.rf_we   = disp_rf_we[1'(s)];
                    e.payload = disp_payload[1'(s)];
                    ent_d[IDX_W'(wr)] = e;
                    wr = wr + CNT_W'(1);
                end
            end
        end
        occ_d = wr;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[IDX_W'(i)].valid = 1'b0;
            end
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[IDX_W'(i)] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[IDX_W'(i)] <= ent_d[IDX_W'(i)];
            end
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_2w.sv
// Directed bench for issue_queue_2w: dispatch, wakeup, stall, collapse, flush and async reset.
module tb_issue_queue_2w;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic [1:0]       disp_valid;
    logic             disp_ready;
    logic [1:0][4:0]  disp_src1;
    logic [1:0][4:0]  disp_src2;
    logic [1:0]       disp_src1_rdy;
    logic [1:0]       disp_src2_rdy;
    logic [1:0][4:0]  disp_dest;
    logic [1:0]       disp_rf_we;
    logic [1:0][63:0] disp_payload;
    logic [1:0]       iss_valid;
    logic             iss_ready;
    logic [1:0][63:0] iss_payload;
    logic [4:0]       sel_inst1_dest;
    logic [4:0]       sel_inst2_dest;
    logic [4:0]       wb_inst1_dest;
    logic [4:0]       wb_inst2_dest;
    logic [3:0]       occupancy;

    int n_vec = 0;
    int n_bad = 0;

    issue_queue_2w #(.DEPTH(8), .REG_W(5), .PAYLOAD_W(64)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_src1      (disp_src1),
        .disp_src2      (disp_src2),
        .disp_src1_rdy  (disp_src1_rdy),
        .disp_src2_rdy  (disp_src2_rdy),
        .disp_dest      (disp_dest),
        .disp_rf_we     (disp_rf_we),
        .disp_payload   (disp_payload),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_payload    (iss_payload),
        .sel_inst1_dest (sel_inst1_dest),
        .sel_inst2_dest (sel_inst2_dest),
        .wb_inst1_dest  (wb_inst1_dest),
        .wb_inst2_dest  (wb_inst2_dest),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        disp_valid    = '0;
        disp_src1     = '0;
        disp_src2     = '0;
        disp_src1_rdy = '0;
        disp_src2_rdy = '0;
        disp_dest     = '0;
        disp_rf_we    = '0;
        disp_payload  = '0;
        wb_inst1_dest = '0;
        wb_inst2_dest = '0;
    endtask

    task automatic put(input logic s, input logic [4:0] s1, input logic r1,
                       input logic [4:0] dst, input logic [63:0] pl);
        disp_valid[s]    = 1'b1;
        disp_src1[s]     = s1;
        disp_src1_rdy[s] = r1;
        disp_src2[s]     = 5'd0;
        disp_src2_rdy[s] = 1'b0;
        disp_dest[s]     = dst;
        disp_rf_we[s]    = 1'b1;
        disp_payload[s]  = pl;
    endtask

    initial begin
        idle();
        iss_ready = 1'b0;
        resetn    = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check_val("rst_iss_valid", 64'(iss_valid), 64'd0);
        check_val("rst_sel1", 64'(sel_inst1_dest), 64'd0);
        check_val("rst_sel2", 64'(sel_inst2_dest), 64'd0);
        check_val("rst_occ", 64'(occupancy), 64'd0);
        check_val("rst_disp_ready", 64'(disp_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // two independent ops in one dispatch
        tick();
        put(1'b0, 5'd0, 1'b0, 5'd3, 64'hA0);
        put(1'b1, 5'd0, 1'b0, 5'd4, 64'hA1);
        #1 check_val("t1_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        idle();
        iss_ready = 1'b1;
        #1;
        check_val("t1_iss_valid", 64'(iss_valid), 64'd3);
        check_val("t1_pay0", iss_payload[0], 64'hA0);
        check_val("t1_pay1", iss_payload[1], 64'hA1);
        check_val("t1_sel1", 64'(sel_inst1_dest), 64'd3);
        check_val("t1_sel2", 64'(sel_inst2_dest), 64'd4);
        check_val("t1_occ2", 64'(occupancy), 64'd2);
        tick();
        #1;
        check_val("t1_occ0", 64'(occupancy), 64'd0);
        check_val("t1_empty", 64'(iss_valid), 64'd0);

        // back-to-back dependent issue
        put(1'b0, 5'd0, 1'b0, 5'd5, 64'hB0);
        tick();
        idle();
        put(1'b0, 5'd5, 1'b0, 5'd6, 64'hB1);
        #1;
        check_val("t2_a_valid", 64'(iss_valid), 64'd1);
        check_val("t2_a_pay", iss_payload[0], 64'hB0);
        check_val("t2_a_sel1", 64'(sel_inst1_dest), 64'd5);
        check_val("t2_a_sel2", 64'(sel_inst2_dest), 64'd0);
        tick();
        idle();
        #1;
        check_val("t2_b_valid", 64'(iss_valid), 64'd1);
        check_val("t2_b_pay", iss_payload[0], 64'hB1);
        check_val("t2_b_sel1", 64'(sel_inst1_dest), 64'd6);
        tick();
        #1 check_val("t2_occ0", 64'(occupancy), 64'd0);

        // fill seven not-ready entries: src1 = 10+k, dest = 20+k, payload = 0x300+k
        iss_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle();
            put(1'b0, 5'(10 + 2*c), 1'b0, 5'(20 + 2*c), 64'(32'h300 + 2*c));
            if (c < 3) put(1'b1, 5'(11 + 2*c), 1'b0, 5'(21 + 2*c), 64'(32'h301 + 2*c));
            #1 check_val("t3_fill_ready", 64'(disp_ready), 64'd1);
            tick();
        end
        idle();
        #1;
        check_val("t3_full_ready", 64'(disp_ready), 64'd0);
        check_val("t3_occ7", 64'(occupancy), 64'd7);
        check_val("t3_none_valid", 64'(iss_valid), 64'd0);
        wb_inst1_dest = 5'd13;
        iss_ready     = 1'b1;
        tick();
        idle();
        #1;
        check_val("t3_e3_valid", 64'(iss_valid), 64'd1);
        check_val("t3_e3_pay", iss_payload[0], 64'h303);
        check_val("t3_e3_sel1", 64'(sel_inst1_dest), 64'd23);
        tick();
        #1;
        check_val("t3_occ6", 64'(occupancy), 64'd6);
        check_val("t3_ready_back", 64'(disp_ready), 64'd1);

        // collapsed order e0 e1 e2 e4 e5 e6: wake index 1 (e1) and 4 (e5), stall three cycles
        wb_inst1_dest = 5'd11;
        wb_inst2_dest = 5'd15;
        iss_ready     = 1'b0;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t4_hold_valid", 64'(iss_valid), 64'd3);
            check_val("t4_hold_pay0", iss_payload[0], 64'h301);
            check_val("t4_hold_pay1", iss_payload[1], 64'h305);
            check_val("t4_hold_sel1", 64'(sel_inst1_dest), 64'd0);
            check_val("t4_hold_sel2", 64'(sel_inst2_dest), 64'd0);
            tick();
        end
        iss_ready = 1'b1;
        #1;
        check_val("t4_rel_sel1", 64'(sel_inst1_dest), 64'd21);
        check_val("t4_rel_sel2", 64'(sel_inst2_dest), 64'd25);
        tick();
        #1 check_val("t4_occ4", 64'(occupancy), 64'd4);
        // remaining e0 e2 e4 e6: wake youngest and oldest, port 0 must be the older one
        wb_inst1_dest = 5'd16;
        wb_inst2_dest = 5'd10;
        iss_ready     = 1'b0;
        tick();
        idle();
        #1;
        check_val("t4_age_valid", 64'(iss_valid), 64'd3);
        check_val("t4_age_pay0", iss_payload[0], 64'h300);
        check_val("t4_age_pay1", iss_payload[1], 64'h306);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1 check_val("t4_occ2", 64'(occupancy), 64'd2);

        // dispatch-cycle wakeup bypass from wb_inst2_dest
        put(1'b0, 5'd7, 1'b0, 5'd8, 64'h500);
        wb_inst2_dest = 5'd7;
        tick();
        idle();
        #1;
        check_val("t5_valid", 64'(iss_valid), 64'd1);
        check_val("t5_pay", iss_payload[0], 64'h500);
        check_val("t5_occ3", 64'(occupancy), 64'd3);
        iss_ready = 1'b1;
        #1 check_val("t5_sel1", 64'(sel_inst1_dest), 64'd8);
        tick();
        iss_ready = 1'b0;
        #1 check_val("t5_occ2", 64'(occupancy), 64'd2);

        // flush wins over simultaneous dispatch and issue
        wb_inst1_dest = 5'd12;
        tick();
        idle();
        iss_ready = 1'b1;
        flush     = 1'b1;
        put(1'b0, 5'd0, 1'b0, 5'd2, 64'h600);
        #1 check_val("t6_pre_valid", 64'(iss_valid), 64'd1);
        tick();
        idle();
        iss_ready = 1'b0;
        #1;
        check_val("t6_flush_occ", 64'(occupancy), 64'd0);
        check_val("t6_flush_valid", 64'(iss_valid), 64'd0);

        // async reset mid-stream
        put(1'b0, 5'd0, 1'b0, 5'd9, 64'h700);
        put(1'b1, 5'd0, 1'b0, 5'd10, 64'h701);
        tick();
        idle();
        iss_ready = 1'b1;
        #1;
        check_val("t7_pre_valid", 64'(iss_valid), 64'd3);
        check_val("t7_pre_sel1", 64'(sel_inst1_dest), 64'd9);
        resetn = 1'b0;
        #1;
        check_val("t7_rst_valid", 64'(iss_valid), 64'd0);
        check_val("t7_rst_sel1", 64'(sel_inst1_dest), 64'd0);
        check_val("t7_rst_sel2", 64'(sel_inst2_dest), 64'd0);
        check_val("t7_rst_occ", 64'(occupancy), 64'd0);
        check_val("t7_rst_ready", 64'(disp_ready), 64'd1);
        #3 resetn = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
